lmsm_mem_sequencer: RTL and testbench

- Initiator side of the word-memory interface: drives the 6-bit address, 16-bit write data and active-low read/write strobes that the 64x16 memory samples on negedge clk.
- Executes the multi-register transfers for LM (memory to register file) and SM (register file to memory).
- Given a base address and an 8-bit register list, it performs one memory access per set bit, lowest register first, at consecutive addresses.
- Sits between the multicycle control FSM and the memory/register file.

---
 rtl/lmsm_pkg.sv | 18 +
 rtl/lmsm_prio_enc.sv | 25 ++
 rtl/lmsm_mem_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lmsm_mem_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared types and constants for the LM/SM memory sequencer.
// State encoding, transfer mode and active-low strobe levels.
package lmsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_LM    = 1'b0;
    localparam logic MODE_SM    = 1'b1;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/lmsm_prio_enc.sv
// lmsm_prio_enc: lowest-set-bit priority encoder over the register list.
// o_valid is low when the mask is empty; o_idx is then 0.
module lmsm_prio_enc
    import lmsm_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic [NREG-1:0]         i_mask,
    output logic [$clog2(NREG)-1:0] o_idx,
    output logic                    o_valid
);

    // Scan high to low so the lowest set bit is written last and wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = ($clog2(NREG))'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_mem_sequencer.sv
// lmsm_mem_sequencer: LM/SM multi-register transfer engine, one access per set bit.
// Optional LMSM_WRAP_ERR_EN builds a sticky address-wrap error flag.
module lmsm_mem_sequencer
    import lmsm_pkg::*;
#(
    parameter int AW   = 6,
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    proc_rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [AW-1:0]           base_addr,
    input  logic [NREG-1:0]         reg_list,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DW-1:0]           mem_rdata,
    output logic [$clog2(NREG)-1:0] rf_raddr,
    input  logic [DW-1:0]           rf_rdata,
    output logic [$clog2(NREG)-1:0] rf_waddr,
    output logic [DW-1:0]           rf_wdata,
    output logic                    rf_wen,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int IW = $clog2(NREG);

    state_t            r_state;
    logic              r_mode;
    logic [AW-1:0]     r_addr;
    logic [NREG-1:0]   r_mask;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DW-1:0]     r_rdata;

    state_t            w_state_n;
    logic              w_mode_n;
    logic [AW-1:0]     w_addr_n;
    logic [NREG-1:0]   w_mask_n;
    logic [AW-1:0]     w_mem_addr_n;
    logic [DW-1:0]     w_mem_wdata_n;
    logic              w_mem_read_n;
    logic              w_mem_write_n;
    logic [DW-1:0]     w_rdata_n;

    logic [IW-1:0]     w_idx;
    logic              w_valid;
    logic [NREG-1:0]   w_clr;
    logic [AW-1:0]     w_addr_inc;

    lmsm_prio_enc #(
        .NREG    (NREG)
    ) u_enc (
        .i_mask  (r_mask),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_clr      = r_mask & ~(NREG'(1) << w_idx);
    assign w_addr_inc = r_addr + AW'(1);

    // Next state plus next values of the registered memory-side outputs.
    always_comb begin
        w_state_n     = r_state;
        w_mode_n      = r_mode;
        w_addr_n      = r_addr;
        w_mask_n      = r_mask;
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
        w_mem_read_n  = STROBE_OFF;
        w_mem_write_n = STROBE_OFF;
        w_rdata_n     = r_rdata;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_n = mode;
                    w_addr_n = base_addr;
                    w_mask_n = reg_list;
                    if (reg_list == '0) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_state_n = ST_FETCH;
                        if (mode == MODE_LM) begin
                            w_mem_read_n = STROBE_ON;
                            w_mem_addr_n = base_addr;
                        end
                    end
                end
            end
            ST_FETCH: begin
                w_state_n = ST_XFER;
                if (r_mode == MODE_SM) begin
                    w_mem_write_n = STROBE_ON;
                    w_mem_addr_n  = r_addr;
                    w_mem_wdata_n = rf_rdata;
                end else begin
                    w_rdata_n = mem_rdata;
                end
            end
            ST_XFER: begin
                w_mask_n = w_clr;
                w_addr_n = w_addr_inc;
                if (!w_valid || w_clr == '0) begin
                    w_state_n = ST_DONE;
                end else begin
                    w_state_n = ST_FETCH;
                    if (r_mode == MODE_LM) begin
                        w_mem_read_n = STROBE_ON;
                        w_mem_addr_n = w_addr_inc;
                    end
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and glitch-free memory-side outputs, all from flops.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_LM;
            r_addr      <= '0;
            r_mask      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= STROBE_OFF;
            r_mem_write <= STROBE_OFF;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_mode      <= w_mode_n;
            r_addr      <= w_addr_n;
            r_mask      <= w_mask_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_read  <= w_mem_read_n;
            r_mem_write <= w_mem_write_n;
            r_rdata     <= w_rdata_n;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign rf_raddr  = w_idx;
    assign rf_waddr  = w_idx;
    assign rf_wdata  = r_rdata;
    assign rf_wen    = (r_state == ST_XFER) && (r_mode == MODE_LM);
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_XFER);
    assign done      = (r_state == ST_DONE);

`ifdef LMSM_WRAP_ERR_EN
    logic r_err;

    // Sticky wrap flag: set when 2^AW-1 rolls to 0 with registers still pending.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_err <= 1'b0;
        end else if (r_state == ST_XFER && r_addr == '1 && w_clr != '0) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
// tb_lmsm_mem_sequencer: directed bench with a negedge 64x16 memory model
// and an 8-entry register-file model around lmsm_mem_sequencer.
module tb_lmsm_mem_sequencer;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        start;
    logic        mode;
    logic [5:0]  base_addr;
    logic [7:0]  reg_list;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_wen;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem [0:63];
    logic [15:0] rf  [0:7];

    logic        pl_en = 1'b0;
    logic        pl_rf = 1'b0;
    logic [5:0]  pl_a  = '0;
    logic [15:0] pl_d  = '0;

    int n_rd   = 0;
    int n_wr   = 0;
    int n_wen  = 0;
    int n_busy = 0;
    int n_done = 0;
    int n_both = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmsm_mem_sequencer dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .reg_list  (reg_list),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_wen    (rf_wen),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign rf_rdata = rf[rf_raddr];

    // Memory and register file act on negedge; activity counters sampled there too.
    always @(negedge clk) begin
        if (pl_en) begin
            if (pl_rf) rf[pl_a[2:0]] = pl_d;
            else       mem[pl_a]     = pl_d;
        end
        if (mem_write == 1'b0) mem[mem_addr] = mem_wdata;
        if (mem_read == 1'b0)  mem_rdata = mem[mem_addr];
        if (rf_wen)            rf[rf_waddr] = rf_wdata;
        if (mem_read == 1'b0)  n_rd++;
        if (mem_write == 1'b0) n_wr++;
        if (rf_wen)            n_wen++;
        if (busy)              n_busy++;
        if (done)              n_done++;
        if (!mem_read && !mem_write) n_both++;
    end

    task automatic poke(input logic is_rf, input logic [5:0] a, input logic [15:0] d);
        pl_rf = is_rf;
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_xfer(input logic m, input logic [5:0] b,
                            input logic [7:0] l, output int lat);
        lat = -1;
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; base_addr = b; reg_list = l;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start = 1'b0; mode = ~m; base_addr = ~b; reg_list = ~l;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_rst = 1'b0;
        start = 1'b0; mode = 1'b0; base_addr = '0; reg_list = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mem_read got %b want 1", mem_read); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mem_write got %b want 1", mem_write); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_rf_wen got %b want 0", rf_wen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL rst_rf_waddr got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 16'h0) begin errors++; $display("FAIL rst_rf_wdata got %h want 0", rf_wdata); end
        proc_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_sm();
        int lat;
        int w0;
        int e0;
        for (int i = 0; i < 8; i++) poke(1'b1, 6'(i), 16'h1000 + 16'(i));
        poke(1'b0, 6'd20, 16'hFFFF);
        poke(1'b0, 6'd21, 16'hFFFF);
        w0 = n_wr; e0 = n_wen;
        run_xfer(1'b1, 6'd20, 8'h05, lat);
        checks++; if (mem[20] !== 16'h1000) begin errors++; $display("FAIL sm_mem20 got %h want 1000", mem[20]); end
        checks++; if (mem[21] !== 16'h1002) begin errors++; $display("FAIL sm_mem21 got %h want 1002", mem[21]); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sm_latency got %0d want 5", lat); end
        checks++; if (n_wen - e0 !== 0) begin errors++; $display("FAIL sm_rf_wen got %0d want 0", n_wen - e0); end
        checks++; if (n_wr - w0 !== 2) begin errors++; $display("FAIL sm_writes got %0d want 2", n_wr - w0); end
    endtask

    task automatic test_lm();
        int lat;
        int w0;
        int r0;
        poke(1'b0, 6'd2, 16'd2);
        poke(1'b0, 6'd3, 16'd3);
        poke(1'b0, 6'd4, 16'd4);
        w0 = n_wr; r0 = n_rd;
        run_xfer(1'b0, 6'd2, 8'h8A, lat);
        checks++; if (rf[1] !== 16'd2) begin errors++; $display("FAIL lm_r1 got %h want 0002", rf[1]); end
        checks++; if (rf[3] !== 16'd3) begin errors++; $display("FAIL lm_r3 got %h want 0003", rf[3]); end
        checks++; if (rf[7] !== 16'd4) begin errors++; $display("FAIL lm_r7 got %h want 0004", rf[7]); end
        checks++; if (rf[0] !== 16'h1000) begin errors++; $display("FAIL lm_r0_kept got %h want 1000", rf[0]); end
        checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL lm_writes got %0d want 0", n_wr - w0); end
        checks++; if (n_rd - r0 !== 3) begin errors++; $display("FAIL lm_reads got %0d want 3", n_rd - r0); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL lm_latency got %0d want 7", lat); end
    endtask

    task automatic test_empty();
        int lat;
        int s0;
        int b0;
        int d0;
        s0 = n_rd + n_wr; b0 = n_busy; d0 = n_done;
        run_xfer(1'b0, 6'd7, 8'h00, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency got %0d want 1", lat); end
        checks++; if (n_busy - b0 !== 0) begin errors++; $display("FAIL empty_busy got %0d want 0", n_busy - b0); end
        checks++; if (n_rd + n_wr - s0 !== 0) begin errors++; $display("FAIL empty_strobes got %0d want 0", n_rd + n_wr - s0); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL empty_done got %0d want 1", n_done - d0); end
    endtask

    task automatic test_wrap();
        int lat;
        logic exp_err;
`ifdef LMSM_WRAP_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        poke(1'b0, 6'd63, 16'hFFFF);
        poke(1'b0, 6'd0, 16'hFFFF);
        run_xfer(1'b1, 6'd63, 8'h03, lat);
        checks++; if (mem[63] !== 16'h1000) begin errors++; $display("FAIL wrap_mem63 got %h want 1000", mem[63]); end
        checks++; if (mem[0] !== 16'h0002) begin errors++; $display("FAIL wrap_mem0 got %h want 0002", mem[0]); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency got %0d want 5", lat); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL wrap_err got %b want %b", err, exp_err); end
        run_xfer(1'b1, 6'd40, 8'h01, lat);
        checks++; if (mem[40] !== 16'h1000) begin errors++; $display("FAIL noerr_mem40 got %h want 1000", mem[40]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
    endtask

    task automatic test_async_reset();
        int lat;
        int d0;
        poke(1'b0, 6'd10, 16'hA0A0);
        poke(1'b0, 6'd11, 16'hA1A1);
        poke(1'b0, 6'd12, 16'hA2A2);
        poke(1'b0, 6'd5, 16'h0505);
        poke(1'b1, 6'd1, 16'h5555);
        d0 = n_done;
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b0; base_addr = 6'd10; reg_list = 8'h07;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL ar_in_xfer got %b want 1", rf_wen); end
        #1 proc_rst = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL ar_rf_wen got %b want 0", rf_wen); end
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL ar_mem_read got %b want 1", mem_read); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL ar_mem_write got %b want 1", mem_write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1 proc_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL ar_no_done got %0d want 0", n_done - d0); end
        checks++; if (rf[0] !== 16'hA0A0) begin errors++; $display("FAIL ar_r0 got %h want a0a0", rf[0]); end
        checks++; if (rf[1] !== 16'h5555) begin errors++; $display("FAIL ar_r1_kept got %h want 5555", rf[1]); end
        run_xfer(1'b0, 6'd5, 8'h01, lat);
        checks++; if (rf[0] !== 16'h0505) begin errors++; $display("FAIL ar_restart_r0 got %h want 0505", rf[0]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL ar_restart_latency got %0d want 3", lat); end
    endtask

    task automatic test_start_ignored();
        int lat;
        int w0;
        int r0;
        int d0;
        poke(1'b1, 6'd2, 16'h2222);
        poke(1'b0, 6'd30, 16'hFFFF);
        poke(1'b0, 6'd31, 16'hFFFF);
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        lat = -1;
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; base_addr = 6'd30; reg_list = 8'h06;
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b0; base_addr = 6'd50; reg_list = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 3; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (lat !== 5) begin errors++; $display("FAIL ign_latency got %0d want 5", lat); end
        checks++; if (n_wr - w0 !== 2) begin errors++; $display("FAIL ign_writes got %0d want 2", n_wr - w0); end
        checks++; if (n_rd - r0 !== 0) begin errors++; $display("FAIL ign_reads got %0d want 0", n_rd - r0); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL ign_done got %0d want 1", n_done - d0); end
        checks++; if (mem[30] !== 16'h5555) begin errors++; $display("FAIL ign_mem30 got %h want 5555", mem[30]); end
        checks++; if (mem[31] !== 16'h2222) begin errors++; $display("FAIL ign_mem31 got %h want 2222", mem[31]); end
    endtask

    initial begin
        test_reset();
        test_sm();
        test_lm();
        test_empty();
        test_wrap();
        test_async_reset();
        test_start_ignored();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL both_strobes got %0d want 0", n_both); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
